// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Single-outstanding instruction fetch front end with PC ownership,
//            request/grant/response memory handshake and branch redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] c_RESET_PC = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_req;
    logic        r_valid;
    logic        r_err;

    logic [31:0] w_target;
    logic        w_unused_result;

    assign w_target        = {Result[31:2], 2'b00};
    assign w_unused_result = ^Result[1:0];

    // Request/valid flags are registered alongside the state so that no
    // imem_* or Stall input ever reaches them combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= c_RESET_PC;
            r_instr <= 32'h0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_rvalid) begin
                        r_err <= 1'b1;
                    end
                    if (imem_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (imem_rvalid) begin
                        r_err <= 1'b1;
                    end
                    if (!Stall) begin
                        r_pc    <= PCSrc ? w_target : (r_pc + 32'd4);
                        r_state <= S_FETCH;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign Instr      = r_instr;
    assign InstrValid = r_valid;
    assign PC         = r_pc;
    assign PCPlus8    = r_pc + 32'd8;
    assign FetchErr   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit: directed scenarios plus
//            randomized handshake/stall/redirect traffic against a cycle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] c_RST_PC = 32'h0000_0000;
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_WAIT  = 2;
    localparam int P_HOLD  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] Result = 32'h0;
    logic        Stall = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        FetchErr;

    instr_fetch_unit #(.RESET_PC(c_RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .Result     (Result),
        .Stall      (Stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus8    (PCPlus8),
        .FetchErr   (FetchErr)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_pc    = c_RST_PC;
        m_instr = 32'h0;
        m_err   = 1'b0;
    endfunction

    // One instruction = FETCH until granted, WAIT until data, HOLD until consumed.
    function automatic void model_edge();
        case (m_phase)
            P_IDLE:  m_phase = P_FETCH;
            P_FETCH: begin
                if (imem_rvalid) m_err = 1'b1;
                if (imem_gnt) m_phase = P_WAIT;
            end
            P_WAIT: begin
                if (imem_rvalid) begin
                    m_instr = imem_rdata;
                    m_phase = P_HOLD;
                end
            end
            default: begin
                if (imem_rvalid) m_err = 1'b1;
                if (!Stall) begin
                    m_pc    = PCSrc ? (Result & 32'hFFFF_FFFC) : (m_pc + 32'd4);
                    m_phase = P_FETCH;
                end
            end
        endcase
    endfunction

    task automatic compare_all();
        chk("imem_req", imem_req, m_phase == P_FETCH);
        chk("InstrValid", InstrValid, m_phase == P_HOLD);
        chk("FetchErr", FetchErr, m_err);
        if (m_phase == P_FETCH) chk("imem_addr", imem_addr, m_pc);
        if (m_phase == P_HOLD) begin
            chk("Instr", Instr, m_instr);
            chk("PC", PC, m_pc);
            chk("PCPlus8", PCPlus8, m_pc + 32'd8);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        else model_reset();
        #1;
        compare_all();
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    task automatic drive(input int gp, input int rp, input int sp, input int pp);
        imem_gnt    = (m_phase == P_FETCH) && (int'($urandom_range(99)) < gp);
        imem_rvalid = (m_phase == P_WAIT) && (int'($urandom_range(99)) < rp);
        imem_rdata  = $urandom;
        Stall       = int'($urandom_range(99)) < sp;
        PCSrc       = int'($urandom_range(99)) < pp;
        Result      = $urandom;
    endtask

    task automatic run_to(input int phase, input int maxc);
        int n;
        n = 0;
        while (m_phase != phase && n < maxc) begin
            drive(100, 100, 0, 0);
            step();
            n++;
        end
        chk("run_to_timeout", m_phase, phase);
    endtask

    logic [31:0] saved;
    int          gp, rp, sp, pp;

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", InstrValid, 1'b0);
        chk("rst_err", FetchErr, 1'b0);
        chk("rst_addr", imem_addr, c_RST_PC);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_pc8", PCPlus8, c_RST_PC + 32'd8);
        step();
        reset = 1'b1;

        // Back-to-back fetches with immediate grant and next-cycle response.
        for (int k = 1; k <= 13; k++) begin
            drive(100, 100, 0, 0);
            step();
            chk("seq_req", imem_req, (k % 3) == 1);
            chk("seq_valid", InstrValid, (k % 3) == 0);
            if ((k % 3) == 1) chk("seq_addr", imem_addr, ((k - 1) / 3) * 4);
            if (k == 3) chk("seq_pc8", PCPlus8, 32'h8);
        end

        // Grant withheld for three cycles, response two cycles after grant.
        Stall = 1'b0;
        PCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gw_req", imem_req, 1'b1);
            chk("gw_addr", imem_addr, 32'h10);
        end
        imem_gnt = 1'b1;
        step();
        step();
        chk("gw_notyet", InstrValid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        chk("gw_valid", InstrValid, 1'b1);
        chk("gw_instr", Instr, 32'h1234_5678);
        chk("gw_err", FetchErr, 1'b0);

        // Stall with redirect toggling underneath, then a redirect consume.
        for (int i = 0; i < 4; i++) begin
            Stall  = 1'b1;
            PCSrc  = i[0];
            Result = 32'h200;
            step();
            chk("st_valid", InstrValid, 1'b1);
            chk("st_pc", PC, 32'h10);
            chk("st_req", imem_req, 1'b0);
        end
        Stall  = 1'b0;
        PCSrc  = 1'b1;
        Result = 32'h203;
        step();
        chk("rd_addr", imem_addr, 32'h200);

        // Redirect to the top word, then sequential wrap to zero.
        imem_gnt = 1'b1;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA0A0_0200;
        step();
        PCSrc  = 1'b1;
        Result = 32'hFFFF_FFFF;
        step();
        chk("wr_top", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        step();
        imem_rvalid = 1'b1;
        step();
        chk("wr_pc", PC, 32'hFFFF_FFFC);
        chk("wr_pc8", PCPlus8, 32'h4);
        PCSrc = 1'b0;
        step();
        chk("wr_addr", imem_addr, 32'h0);

        // Randomized traffic in blocks with varying pressure.
        for (int b = 0; b < 12; b++) begin
            gp = int'($urandom_range(100, 20));
            rp = int'($urandom_range(100, 20));
            sp = int'($urandom_range(70, 0));
            pp = int'($urandom_range(100, 0));
            for (int i = 0; i < 50; i++) begin
                drive(gp, rp, sp, pp);
                step();
            end
        end

        // Spurious response while holding an instruction.
        run_to(P_HOLD, 20);
        saved       = Instr;
        Stall       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        chk("sp_err", FetchErr, 1'b1);
        chk("sp_instr", Instr, saved);
        chk("sp_valid", InstrValid, 1'b1);
        for (int i = 0; i < 60; i++) begin
            drive(80, 80, 30, 50);
            step();
        end
        chk("sp_sticky", FetchErr, 1'b1);

        // Reset in WAIT, stale response arriving in IDLE.
        run_to(P_WAIT, 20);
        reset = 1'b0;
        model_reset();
        #1;
        chk("mr_req", imem_req, 1'b0);
        chk("mr_valid", InstrValid, 1'b0);
        chk("mr_err", FetchErr, 1'b0);
        chk("mr_addr", imem_addr, c_RST_PC);
        chk("mr_instr", Instr, 32'h0);
        chk("mr_pc", PC, c_RST_PC);
        step();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        step();
        chk("mr_stale_err", FetchErr, 1'b0);
        chk("mr_refetch", imem_addr, c_RST_PC);
        chk("mr_refetch_req", imem_req, 1'b1);
        imem_gnt = 1'b1;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_600D;
        step();
        chk("mr_instr_new", Instr, 32'h0000_600D);
        chk("mr_err_end", FetchErr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
